// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment bit order is g..a (bit 0 = segment a), active-high.
package disp_pkg;

  localparam int DISP_MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a registered one-cycle tick every DIV cycles.
// The tick is high in the cycle where the internal count sits at DIV-1.
module tick_divider
  import disp_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          tick_r;

  // next count with wrap at DIV-1
  always_comb begin
    count_next_s = count_r;
    if (count_r == LAST) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + CW'(1);
    end
  end

  // count and tick registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= (count_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/seg_display_mux.sv
// N-digit multiplexed common-anode 7-segment driver with PWM brightness,
// dead time, per-digit blanking/blink and a frame marker.
module seg_display_mux
  import disp_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int DIGITS   = 4,
  parameter int SLOT_HZ  = 800,
  parameter int DEAD_CYC = 2,
  parameter int BRIGHT_W = 4,
  parameter int BLINK_HZ = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7*DIGITS-1:0]   display,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            cat,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int SLOT_DIV  = CLK_HZ / SLOT_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W     = (clog2(SLOT_DIV) < 1) ? 1 : clog2(SLOT_DIV);
  localparam int IDX_W     = clog2(DISP_MAX_DIGITS);
  // wide enough that (brightness+1)*SLOT_DIV never overflows
  localparam int WIN_W     = CNT_W + BRIGHT_W + 1;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [WIN_W-1:0]  DEAD_W   = WIN_W'(DEAD_CYC);
  localparam logic [WIN_W-1:0]  DIV_W    = WIN_W'(SLOT_DIV);
  localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{1'b1}};

  logic                slot_tick_s;
  logic                blink_tick_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                phase_r;

  logic [6:0]          seg_lat_r;
  logic                dp_lat_r;
  logic                blank_lat_r;
  logic                blink_lat_r;
  logic                phase_lat_r;
  logic [BRIGHT_W-1:0] bright_lat_r;

  logic [6:0]          seg_live_s;
  logic                dp_live_s;
  logic                blank_live_s;
  logic                blink_live_s;

  logic [6:0]          seg_s;
  logic                dp_s;
  logic                blank_s;
  logic                blink_s;
  logic                phase_s;
  logic [BRIGHT_W-1:0] bright_s;

  logic [WIN_W-1:0]    on_win_s;
  logic [WIN_W-1:0]    cnt_wide_s;
  logic                lit_s;
  logic [DIGITS-1:0]   an_lit_s;

  logic [DIGITS-1:0]   an_r;
  logic [6:0]          cat_r;
  logic                dp_n_r;
  logic                frame_start_r;

  tick_divider #(.DIV(SLOT_DIV)) u_slot_div (
    .clock (clock),
    .reset (reset),
    .tick  (slot_tick_s)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clock (clock),
    .reset (reset),
    .tick  (blink_tick_s)
  );

  // slot counter and digit index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (slot_tick_s) begin
      cnt_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // free-running blink phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_r <= 1'b0;
    end else if (blink_tick_s) begin
      phase_r <= ~phase_r;
    end else begin
      phase_r <= phase_r;
    end
  end

  assign seg_live_s   = 7'(display >> (32'd7 * 32'(idx_r)));
  assign dp_live_s    = 1'(dp >> idx_r);
  assign blank_live_s = 1'(blank >> idx_r);
  assign blink_live_s = 1'(blink >> idx_r);

  // slot data latch, taken once at the start of every slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_lat_r    <= SEG_OFF;
      dp_lat_r     <= 1'b0;
      blank_lat_r  <= 1'b1;
      blink_lat_r  <= 1'b0;
      phase_lat_r  <= 1'b0;
      bright_lat_r <= '0;
    end else if (cnt_r == '0) begin
      seg_lat_r    <= seg_live_s;
      dp_lat_r     <= dp_live_s;
      blank_lat_r  <= blank_live_s;
      blink_lat_r  <= blink_live_s;
      phase_lat_r  <= phase_r;
      bright_lat_r <= brightness;
    end else begin
      seg_lat_r    <= seg_lat_r;
      dp_lat_r     <= dp_lat_r;
      blank_lat_r  <= blank_lat_r;
      blink_lat_r  <= blink_lat_r;
      phase_lat_r  <= phase_lat_r;
      bright_lat_r <= bright_lat_r;
    end
  end

  // first slot cycle sees the values being latched; later cycles see the latch
  always_comb begin
    seg_s    = seg_lat_r;
    dp_s     = dp_lat_r;
    blank_s  = blank_lat_r;
    blink_s  = blink_lat_r;
    phase_s  = phase_lat_r;
    bright_s = bright_lat_r;
    if (cnt_r == '0) begin
      seg_s    = seg_live_s;
      dp_s     = dp_live_s;
      blank_s  = blank_live_s;
      blink_s  = blink_live_s;
      phase_s  = phase_r;
      bright_s = brightness;
    end else begin
      seg_s    = seg_lat_r;
      dp_s     = dp_lat_r;
      blank_s  = blank_lat_r;
      blink_s  = blink_lat_r;
      phase_s  = phase_lat_r;
      bright_s = bright_lat_r;
    end
  end

  assign cnt_wide_s = WIN_W'(cnt_r);
  assign on_win_s   = ((WIN_W'(bright_s) + WIN_W'(1)) * DIV_W) >> BRIGHT_W;
  assign lit_s      = !blank_s && !(blink_s && phase_s) &&
                      (cnt_wide_s >= DEAD_W) && (cnt_wide_s < on_win_s);
  assign an_lit_s   = ~(AN_ONE << idx_r);

  // registered pin drivers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_r          <= AN_OFF;
      cat_r         <= 7'h7F;
      dp_n_r        <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= (cnt_r == '0) && (idx_r == '0);
      if (lit_s) begin
        an_r   <= an_lit_s;
        cat_r  <= ~seg_s;
        dp_n_r <= ~dp_s;
      end else begin
        an_r   <= AN_OFF;
        cat_r  <= 7'h7F;
        dp_n_r <= 1'b1;
      end
    end
  end

  assign an          = an_r;
  assign cat         = cat_r;
  assign dp_n        = dp_n_r;
  assign frame_start = frame_start_r;

endmodule
